mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the fetch stage (pcF/instrF) and the memory stage (aluoutM/writedataM/readdataM/memwriteM) of the pipelined MIPS core.
//  Arbitrates, sequences variable-latency memory accesses and returns per-side ready strobes; the hazard logic stalls F/M while *_ready is low.
// PARAMETERS
//  AW         32  byte address width
//  DW         32  data width
//  STARVE_MAX 4   consecutive data grants while fetch waits before fetch is forced (>=1)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  if_req     in   1   fetch request (hold until if_ready)
//  if_addr    in   AW  fetch address (pcF)
//  if_rdata   out  DW  fetched instruction, valid while if_ready
//  if_ready   out  1   one-cycle completion strobe, fetch side
//  dm_req     in   1   data request (hold until dm_ready)
//  dm_we      in   1   1=store (memwriteM), 0=load
//  dm_addr    in   AW  data address (aluoutM)
//  dm_wdata   in   DW  store data (writedataM)
//  dm_rdata   out  DW  load data (readdataM), valid while dm_ready
//  dm_ready   out  1   one-cycle completion strobe, data side
//  mem_req    out  1   memory access active
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid with mem_ready
//  mem_ready  in   1   memory completes current access this cycle
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0; all outputs 0 (mem_req, mem_we, *_ready, mem_addr, mem_wdata, *_rdata).
//  FSM: IDLE -> BUSY_I | BUSY_D -> RESP_I | RESP_D -> IDLE.
//  IDLE: no req -> stay. Grant picks a side; addr/we/wdata latched into mem_* regs; mem_req=1 from next cycle.
//  Priority: dm_req wins (older instruction) unless starve_cnt==STARVE_MAX and if_req=1 -> fetch wins.
//  starve_cnt: +1 (saturating at STARVE_MAX) on each data grant with if_req=1; cleared on fetch grant or if_req=0 in IDLE.
//  BUSY_x: mem_req, mem_we, mem_addr, mem_wdata held stable; requester inputs ignored.
//   mem_ready=1 -> capture mem_rdata into x_rdata (loads/fetches; stores leave dm_rdata unchanged) -> RESP_x, mem_req=0 next cycle.
//  RESP_x: x_ready=1 for exactly one cycle, x_rdata stable; -> IDLE. Other side's ready stays 0.
//  Min latency: req in IDLE at cycle 0 -> mem_req cycle 1 -> (mem_ready same cycle) -> x_ready cycle 2 => 3-cycle request-to-ready; each extra memory wait cycle adds one.
//  Back-to-back: new arbitration only in IDLE; max one grant per 3 cycles; no pipelining of accesses.
//  Requester drops req mid-access: access still completes, ready strobe still issued (ignored by requester); no abort.
//  Simultaneous if_req & dm_req in IDLE: one grant; loser stays pending and wins the next IDLE if still requesting alone or by starvation.
//  mem_ready outside BUSY_x: ignored.
//  Reset mid-access: next cycle state=IDLE, mem_req=0, no ready strobe, starve_cnt=0.
//  mem_we=1 only in BUSY_D with latched dm_we=1; never during fetch.
// CONFIGURATION
//  ARB_FETCH_BUF_EN defined:
//   one-entry fetch buffer {valid, tag, data}, set on every completed fetch.
//   In IDLE, if_req with if_addr==tag & valid & no grant to data -> RESP_I without memory access (hit: request-to-ready 2 cycles).
//   Any data store to address == tag clears valid (self-modifying code safe); reset clears valid.
//   Hits do not count as fetch grants for starve_cnt.
//  ARB_FETCH_BUF_EN undefined: no buffer, every fetch goes to memory; timing exactly as above.
// TESTING
//  1 reset, if_req=1 addr=0x0, mem_ready tied 1, mem_rdata=0x20080005 -> mem_req cycle 1, if_ready cycle 2, if_rdata=0x20080005.
//  2 if_req & dm_req (store, addr=0x40, wdata=0xDEADBEEF) same cycle -> data granted first (mem_we=1, mem_addr=0x40); fetch completes next.
//  3 dm_req held continuously with if_req, STARVE_MAX=4 -> exactly 4 data grants, then fetch granted; starve_cnt returns to 0.
//  4 mem_ready low 5 cycles after grant -> mem_addr/mem_we stable throughout; dm_ready 1 cycle after mem_ready, dm_rdata=mem_rdata.
//  5 reset asserted in BUSY_D -> next cycle mem_req=0, no dm_ready, subsequent fetch runs normally.
//  6 ARB_FETCH_BUF_EN: fetch 0x8 twice -> 2nd has no mem_req, if_ready after 2 cycles; store to 0x8 then fetch 0x8 -> goes to memory.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the MIPS fetch/memory stages, the arbiter and the unified memory.
// slave = arbiter view, master = the surrounding core/memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access with starvation guard.
// Optional one-entry fetch buffer enabled by defining ARB_FETCH_BUF_EN.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          fetch_forced;
    logic          data_win;

    // Data side is older in the pipeline, so it wins unless fetch has waited too long.
    assign fetch_forced = bus.if_req && (starve_cnt == CW'(STARVE_MAX));
    assign data_win     = bus.dm_req && !fetch_forced;

`ifdef ARB_FETCH_BUF_EN
    logic          fbuf_valid;
    logic [AW-1:0] fbuf_tag;
    logic [DW-1:0] fbuf_data;
    logic          fbuf_hit;

    assign fbuf_hit = fbuf_valid && (bus.if_addr == fbuf_tag);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= AW'(0);
            bus.mem_wdata <= DW'(0);
            bus.if_ready  <= 1'b0;
            bus.dm_ready  <= 1'b0;
            bus.if_rdata  <= DW'(0);
            bus.dm_rdata  <= DW'(0);
`ifdef ARB_FETCH_BUF_EN
            fbuf_valid    <= 1'b0;
            fbuf_tag      <= AW'(0);
            fbuf_data     <= DW'(0);
`endif
        end else begin
            bus.if_ready <= 1'b0;
            bus.dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_win) begin
                        state         <= BUSY_D;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        if (bus.if_req) begin
                            if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
`ifdef ARB_FETCH_BUF_EN
                    // Buffer hit answers without touching memory and leaves starve_cnt alone.
                    else if (bus.if_req && fbuf_hit) begin
                        state        <= RESP_I;
                        bus.if_ready <= 1'b1;
                        bus.if_rdata <= fbuf_data;
                    end
`endif
                    else if (bus.if_req) begin
                        state         <= BUSY_I;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= DW'(0);
                        starve_cnt    <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ready) begin
                        state        <= RESP_I;
                        bus.mem_req  <= 1'b0;
                        bus.if_ready <= 1'b1;
                        bus.if_rdata <= bus.mem_rdata;
`ifdef ARB_FETCH_BUF_EN
                        fbuf_valid   <= 1'b1;
                        fbuf_tag     <= bus.mem_addr;
                        fbuf_data    <= bus.mem_rdata;
`endif
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ready) begin
                        state        <= RESP_D;
                        bus.mem_req  <= 1'b0;
                        bus.mem_we   <= 1'b0;
                        bus.dm_ready <= 1'b1;
                        if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
`ifdef ARB_FETCH_BUF_EN
                        // Self-modifying code: a store over the buffered word invalidates it.
                        if (bus.mem_we && (bus.mem_addr == fbuf_tag)) fbuf_valid <= 1'b0;
`endif
                    end
                end
                RESP_I:  state <= IDLE;
                RESP_D:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level timeline model.
// Honours ARB_FETCH_BUF_EN when defined for the build.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    bit [31:0] mem_arr [bit [31:0]];
    bit        mem_tie = 1'b0;
    int        cur_lat = 0;
    int        busy_cnt = 0;

    function automatic bit [31:0] rd(input bit [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Memory model: answers after cur_lat wait cycles, or ties mem_ready high.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_tie) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd(bus.mem_addr);
            end else if (bus.mem_req) begin
                if (busy_cnt == cur_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rd(bus.mem_addr);
                    if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    bus.mem_ready = 1'b0;
                end
                busy_cnt++;
            end else begin
                bus.mem_ready = 1'b0;
                busy_cnt = 0;
            end
        end
    end

    // Model state for the random phase.
    longint    t, next_free, acc_start, acc_end, rdy_cycle;
    bit        rdy_data, acc_we, exp_mreq, exp_ifr, exp_dmr, hit;
    bit [31:0] acc_addr, rdy_val, exp_if_rdata, exp_dm_rdata;
    bit        fb_valid;
    bit [31:0] fb_tag, fb_data;
    int        starve, lat, rc, ngrant;
    bit        prev_mreq, stable, seen;
    bit [31:0] grants [$];

    initial begin
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        reset = 1'b1;
        mem_tie = 1'b1;
        mem_arr[32'h0] = 32'h2008_0005;
        repeat (2) step();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_if_ready", bus.if_ready, 0);
        chk("rst_dm_ready", bus.dm_ready, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        reset = 1'b0;
        step();
        chk("idle_tie_mem_req", bus.mem_req, 0);
        chk("idle_tie_if_ready", bus.if_ready, 0);

        // First fetch with mem_ready tied high: 3-cycle request-to-ready.
        bus.if_req = 1; bus.if_addr = 32'h0;
        step();
        chk("t1_mem_req", bus.mem_req, 1);
        chk("t1_if_ready_c1", bus.if_ready, 0);
        step();
        chk("t1_if_ready", bus.if_ready, 1);
        chk("t1_if_rdata", bus.if_rdata, 32'h2008_0005);
        chk("t1_mem_req_off", bus.mem_req, 0);
        bus.if_req = 0; mem_tie = 1'b0; cur_lat = 0;
        step();
        chk("t1_if_ready_once", bus.if_ready, 0);

        // Simultaneous requests: store wins, fetch follows.
        bus.if_req = 1; bus.if_addr = 32'h4;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
        step();
        chk("t2_mem_we", bus.mem_we, 1);
        chk("t2_mem_addr", bus.mem_addr, 32'h40);
        chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("t2_dm_ready", bus.dm_ready, 1);
        chk("t2_if_ready_low", bus.if_ready, 0);
        bus.dm_req = 0;
        step();
        chk("t2_idle_gap", bus.mem_req, 0);
        step();
        chk("t2_fetch_req", bus.mem_req, 1);
        chk("t2_fetch_addr", bus.mem_addr, 32'h4);
        chk("t2_fetch_we", bus.mem_we, 0);
        step();
        chk("t2_if_ready", bus.if_ready, 1);
        chk("t2_if_rdata", bus.if_rdata, rd(32'h4));
        bus.if_req = 0;
        step();

        // Starvation: continuous data requests let fetch in after every STARVE_MAX data grants.
        bus.if_req = 1; bus.if_addr = 32'h8;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
        prev_mreq = 0; grants.delete();
        for (int c = 0; c < 45 && grants.size() < 10; c++) begin
            step();
            if (bus.mem_req && !prev_mreq) grants.push_back(bus.mem_addr);
            prev_mreq = bus.mem_req;
        end
        bus.if_req = 0; bus.dm_req = 0;
        chk("t3_grant_count", 64'(grants.size()), 10);
        for (int g = 0; g < grants.size(); g++)
            chk($sformatf("t3_grant%0d", g), grants[g], ((g % 5) == 4) ? 32'h8 : 32'h100);
        repeat (5) step();

        // Slow memory: request stays stable through 5 wait cycles.
        mem_arr[32'h200] = 32'hCAFE_F00D;
        cur_lat = 5;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200;
        rc = 0; stable = 1;
        for (int c = 1; c <= 20 && rc == 0; c++) begin
            step();
            if (bus.mem_req && (bus.mem_addr !== 32'h200 || bus.mem_we !== 1'b0)) stable = 0;
            if (bus.dm_ready) rc = c;
        end
        chk("t4_mem_stable", stable, 1);
        chk("t4_ready_cycle", rc, 7);
        chk("t4_dm_rdata", bus.dm_rdata, 32'hCAFE_F00D);
        bus.dm_req = 0;
        step();

        // Reset while a store is in flight.
        cur_lat = 10;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h300; bus.dm_wdata = 32'h1111_2222;
        step();
        chk("t5_busy", bus.mem_req, 1);
        reset = 1'b1; bus.dm_req = 0;
        step();
        chk("t5_mem_req_off", bus.mem_req, 0);
        chk("t5_mem_we_off", bus.mem_we, 0);
        chk("t5_no_dm_ready", bus.dm_ready, 0);
        reset = 1'b0;
        seen = 0;
        repeat (3) begin
            step();
            if (bus.dm_ready || bus.mem_req) seen = 1;
        end
        chk("t5_quiet_after_reset", seen, 0);
        cur_lat = 0;
        bus.if_req = 1; bus.if_addr = 32'h10;
        step();
        chk("t5_fetch_req", bus.mem_req, 1);
        chk("t5_fetch_addr", bus.mem_addr, 32'h10);
        step();
        chk("t5_if_ready", bus.if_ready, 1);
        chk("t5_if_rdata", bus.if_rdata, rd(32'h10));
        bus.if_req = 0;
        step();

        // Repeat fetch, then store over it and fetch again.
        bus.if_req = 1; bus.if_addr = 32'h8;
        step();
        chk("t6_first_miss", bus.mem_req, 1);
        step();
        chk("t6_first_ready", bus.if_ready, 1);
        bus.if_req = 0;
        step();
        bus.if_req = 1;
        step();
`ifdef ARB_FETCH_BUF_EN
        chk("t6_hit_no_mem", bus.mem_req, 0);
        chk("t6_hit_ready", bus.if_ready, 1);
`else
        chk("t6_second_mem", bus.mem_req, 1);
        step();
        chk("t6_second_ready", bus.if_ready, 1);
`endif
        chk("t6_second_rdata", bus.if_rdata, rd(32'h8));
        bus.if_req = 0;
        step();
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h8; bus.dm_wdata = 32'h0BAD_F00D;
        step();
        step();
        chk("t6_store_ready", bus.dm_ready, 1);
        bus.dm_req = 0;
        step();
        bus.if_req = 1;
        step();
        chk("t6_after_store_mem", bus.mem_req, 1);
        step();
        chk("t6_after_store_ready", bus.if_ready, 1);
        chk("t6_after_store_rdata", bus.if_rdata, 32'h0BAD_F00D);
        bus.if_req = 0;
        step();

        // Random phase from a fresh reset.
        bus.dm_req = 0; bus.if_req = 0;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        t = 0; next_free = 0; acc_start = -1; acc_end = -2; rdy_cycle = -1;
        starve = 0; fb_valid = 0; exp_dm_rdata = 0; exp_if_rdata = 0; ngrant = 0;
        for (int i = 0; i < 900; i++) begin
            exp_mreq = (t >= acc_start) && (t <= acc_end);
            chk("r_mem_req", bus.mem_req, exp_mreq);
            if (exp_mreq) begin
                chk("r_mem_addr", bus.mem_addr, acc_addr);
                chk("r_mem_we", bus.mem_we, acc_we);
            end
            exp_ifr = (t == rdy_cycle) && !rdy_data;
            exp_dmr = (t == rdy_cycle) && rdy_data;
            chk("r_if_ready", bus.if_ready, exp_ifr);
            chk("r_dm_ready", bus.dm_ready, exp_dmr);
            if (exp_ifr) begin
                exp_if_rdata = rdy_val;
                chk("r_if_rdata", bus.if_rdata, exp_if_rdata);
            end
            if (exp_dmr) begin
                if (!acc_we) exp_dm_rdata = rdy_val;
                chk("r_dm_rdata", bus.dm_rdata, exp_dm_rdata);
            end

            if (exp_ifr) bus.if_req = 0;
            if (exp_dmr) bus.dm_req = 0;
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1;
                bus.if_addr = 32'(4 * $urandom_range(0, 3));
            end
            if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req = 1;
                bus.dm_we = ($urandom_range(0, 2) == 0);
                bus.dm_addr = 32'(4 * $urandom_range(0, 5));
                bus.dm_wdata = $urandom;
            end

            if (t >= next_free) begin
                if (bus.dm_req && !(bus.if_req && starve == int'(STARVE_MAX))) begin
                    starve = bus.if_req ? ((starve < int'(STARVE_MAX)) ? starve + 1 : starve) : 0;
                    lat = $urandom_range(0, 3); cur_lat = lat;
                    acc_start = t + 1; acc_end = t + 1 + lat;
                    rdy_cycle = t + 2 + lat; next_free = t + 3 + lat;
                    acc_addr = bus.dm_addr; acc_we = bus.dm_we;
                    rdy_data = 1; rdy_val = rd(bus.dm_addr);
                    if (bus.dm_we && fb_valid && bus.dm_addr == fb_tag) fb_valid = 0;
                    ngrant++;
                end else if (bus.if_req) begin
                    hit = 0;
`ifdef ARB_FETCH_BUF_EN
                    hit = fb_valid && (fb_tag == bus.if_addr);
`endif
                    rdy_data = 0;
                    if (hit) begin
                        rdy_cycle = t + 1; next_free = t + 2; rdy_val = fb_data;
                    end else begin
                        starve = 0;
                        lat = $urandom_range(0, 3); cur_lat = lat;
                        acc_start = t + 1; acc_end = t + 1 + lat;
                        rdy_cycle = t + 2 + lat; next_free = t + 3 + lat;
                        acc_addr = bus.if_addr; acc_we = 0;
                        rdy_val = rd(bus.if_addr);
                        fb_valid = 1; fb_tag = bus.if_addr; fb_data = rdy_val;
                        ngrant++;
                    end
                end else begin
                    starve = 0;
                end
            end
            t++;
            step();
        end
        chk("r_progress", 64'(ngrant > 50), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
